gpio_bus_arbiter: RTL and testbench
===================================

// Module: gpio_bus_arbiter
// PURPOSE
//   Two-master arbiter/sequencer for the GPIO register port (addr_i/write_en/read_en/wdata/rdata).
//   Lets a CPU-side master (m0) and a hardware sequencer (m1) share one GPIO instance.
//   Arbitrates round-robin, issues one single-cycle strobe per transaction and returns read data
//   with a one-cycle ack pulse. Sits between the masters and the GPIO register interface.
// PARAMETERS
//   AW      5   register address width
//   DW      32  data width
//   RD_LAT  1   cycles from read_en cycle to valid GPIO rdata (1..7)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   m0_req     in   1   master 0 request; hold with m0_we/addr/wdata stable until m0_ack
//   m0_we      in   1   1 = write, 0 = read
//   m0_addr    in   AW  register address
//   m0_wdata   in   DW  write data
//   m0_lock    in   1   keep grant for next transaction (used only with GPIO_ARB_LOCK_EN)
//   m0_ack     out  1   one-cycle completion pulse
//   m0_rdata   out  DW  read data, valid while m0_ack=1
//   m1_*       --   --  identical set for master 1
//   gnt        out  2   one-hot current owner; 00 when idle
//   busy       out  1   1 when FSM not in IDLE
//   addr_o     out  AW  to GPIO addr_i
//   write_en   out  1   to GPIO write strobe
//   read_en    out  1   to GPIO read strobe
//   wdata      out  DW  to GPIO wdata
//   rdata      in   DW  from GPIO rdata
// BEHAVIOUR
//   Reset: FSM=IDLE, all outputs 0, last_gnt=m1, so m0 wins the first tie. Async assert clears
//   mid-transaction: strobes drop immediately, no ack is issued, and the transaction is lost.
//   FSM: IDLE -> ISSUE -> (write: ACK | read: WAIT) -> ACK -> IDLE.
//   - IDLE: if any req, pick winner, latch we/addr/wdata, set gnt, go ISSUE.
//     Otherwise stay in IDLE with gnt=00.
//   - ISSUE (exactly 1 cycle): addr_o/wdata driven; write_en=we or read_en=~we, never both.
//   - WAIT: RD_LAT cycles. rdata is registered at the end of the last WAIT cycle.
//   - ACK: winner's mK_ack=1 for 1 cycle with mK_rdata (0 for writes). last_gnt<=winner.
//   Latency from req sampled in IDLE at cycle T: write ack at T+2; read ack at T+2+RD_LAT.
//   Back-to-back: after ACK the FSM always returns to IDLE (1 idle cycle between transactions).
//   Arbitration: only one req -> that master. Both req -> master != last_gnt (strict alternation).
//   Req dropped mid-transaction: the latched transaction still completes and ack still pulses.
//   Master fields are sampled only in IDLE; later changes are ignored.
//   addr_o/wdata hold their last values outside ISSUE. Strobes are 0 in every state except ISSUE.
//   mK_rdata is 0 whenever mK_ack=0.
// CONFIGURATION
//   GPIO_ARB_LOCK_EN defined:
//     - If the winner's lock=1 during ACK, last_gnt is not updated.
//     - The same master keeps priority in the next IDLE if it requests (atomic read-modify-write).
//     - lock is ignored if that master does not request in the next IDLE cycle.
//   Not defined: lock inputs are unused; pure round-robin.
// TESTING
//   1. Reset, m0 write addr 0x00 data 0x0000000F -> write_en=1 one cycle, addr_o=0x00,
//      m0_ack at T+2, m1_ack=0.
//   2. m1 read 0x1C, GPIO rdata=0x00000100 at RD_LAT=1 -> read_en 1 cycle,
//      m1_ack at T+3, m1_rdata=0x00000100.
//   3. m0 and m1 request together at reset -> m0 served first, m1 next.
//      Both held continuously -> grants alternate m0,m1,m0,m1.
//   4. Reset asserted during WAIT of a read -> read_en=0, busy=0, gnt=00, no ack.
//      After release, a new m0 write completes normally.
//   5. m0 drops req the cycle after ISSUE -> m0_ack still pulses once. No second strobe issued.
//   6. GPIO_ARB_LOCK_EN: m0 read 0x04 with lock=1 while m1 requesting -> m0 next write 0x04
//      granted before m1. Without the macro, m1 is granted next.

Source files
------------

// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer driving one GPIO register port.
// Optional macro GPIO_ARB_LOCK_EN: a winner's lock keeps its priority for the next idle cycle.
module gpio_bus_arbiter #(
  parameter int unsigned AW     = 5,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic [AW-1:0] addr_o,
  output logic          write_en,
  output logic          read_en,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t        state;
  logic          win;       // 0 = m0, 1 = m1
  logic          last;      // master served most recently
  logic          we_q;
  logic [CW-1:0] cnt;

  logic          pick_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;

`ifdef GPIO_ARB_LOCK_EN
  logic hold_vld;
  logic hold_id;
`else
  logic unused_lock;
  assign unused_lock = m0_lock | m1_lock;
`endif

  // Winner selection: locked master first, otherwise alternate on a tie
  always_comb begin
    pick_c = 1'b0;
    if (m0_req && m1_req) begin
      pick_c = ~last;
    end else if (m1_req) begin
      pick_c = 1'b1;
    end
`ifdef GPIO_ARB_LOCK_EN
    if (hold_vld && (hold_id ? m1_req : m0_req)) begin
      pick_c = hold_id;
    end
`endif
    sel_we_c    = pick_c ? m1_we    : m0_we;
    sel_addr_c  = pick_c ? m1_addr  : m0_addr;
    sel_wdata_c = pick_c ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      win      <= 1'b0;
      last     <= 1'b1;
      we_q     <= 1'b0;
      cnt      <= '0;
      gnt      <= 2'b00;
      busy     <= 1'b0;
      addr_o   <= '0;
      wdata    <= '0;
      write_en <= 1'b0;
      read_en  <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
`ifdef GPIO_ARB_LOCK_EN
      hold_vld <= 1'b0;
      hold_id  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef GPIO_ARB_LOCK_EN
          hold_vld <= 1'b0;
`endif
          if (m0_req || m1_req) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            win      <= pick_c;
            gnt      <= pick_c ? 2'b10 : 2'b01;
            we_q     <= sel_we_c;
            addr_o   <= sel_addr_c;
            wdata    <= sel_wdata_c;
            write_en <= sel_we_c;
            read_en  <= ~sel_we_c;
          end
        end
        S_ISSUE: begin
          write_en <= 1'b0;
          read_en  <= 1'b0;
          if (we_q) begin
            state <= S_ACK;
            if (win) m1_ack <= 1'b1;
            else     m0_ack <= 1'b1;
          end else begin
            state <= S_WAIT;
            cnt   <= WAIT_LAST;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_ACK;
            if (win) begin
              m1_ack   <= 1'b1;
              m1_rdata <= rdata;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= rdata;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_ACK: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          gnt      <= 2'b00;
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          m0_rdata <= '0;
          m1_rdata <= '0;
`ifdef GPIO_ARB_LOCK_EN
          if (win ? m1_lock : m0_lock) begin
            hold_vld <= 1'b1;
            hold_id  <= win;
          end else begin
            last <= win;
          end
`else
          last <= win;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: directed spec scenarios plus randomized transactions
// checked against a transaction-level arbitration/timing model and a GPIO register model.
module tb_gpio_bus_arbiter;

  localparam int unsigned AW     = 5;
  localparam int unsigned DW     = 32;
  localparam int unsigned RD_LAT = 1;
`ifdef GPIO_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m0_req, m0_we, m0_lock, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [1:0]    gnt;
  logic          busy, write_en, read_en;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata, rdata;

  gpio_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .gnt(gnt), .busy(busy), .addr_o(addr_o), .write_en(write_en),
    .read_en(read_en), .wdata(wdata), .rdata(rdata)
  );

  // GPIO register file with RD_LAT read pipeline; junk value outside the valid slot
  bit            mem_ready = 1'b0;
  logic [DW-1:0] gmem   [32];
  logic [DW-1:0] pipe_d [RD_LAT];
  logic          pipe_v [RD_LAT];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) gmem[i] <= '0;
      gmem[28] <= 32'h0000_0100;
      for (int i = 0; i < RD_LAT; i++) pipe_v[i] <= 1'b0;
      mem_ready <= 1'b1;
    end else begin
      if (write_en) gmem[addr_o] <= wdata;
      pipe_v[0] <= read_en;
      pipe_d[0] <= gmem[addr_o];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end
  assign rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hDEAD_BEEF;

  // Reference model state
  logic [DW-1:0] exp_mem [32];
  bit last_m;
  bit hold_v;
  bit hold_m;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cur_k   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s step=%0d observed=0x%0h expected=0x%0h", tag, cur_k, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_m = 1'b1;
    hold_v = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    cur_k = -1;
    chk({tag, "_busy"},  DW'(busy),     '0);
    chk({tag, "_gnt"},   DW'(gnt),      '0);
    chk({tag, "_wen"},   DW'(write_en), '0);
    chk({tag, "_ren"},   DW'(read_en),  '0);
    chk({tag, "_ack0"},  DW'(m0_ack),   '0);
    chk({tag, "_ack1"},  DW'(m1_ack),   '0);
    chk({tag, "_rd0"},   m0_rdata,      '0);
    chk({tag, "_rd1"},   m1_rdata,      '0);
    hold_v = 1'b0;
  endtask

  // One transaction starting in the current idle cycle; inputs already driven
  task automatic run_txn(input bit drop);
    bit r0, r1, w, we, lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_rd;
    int lat;
    r0 = m0_req;
    r1 = m1_req;
    if (hold_v && (hold_m ? r1 : r0)) w = hold_m;
    else if (r0 && r1)                w = !last_m;
    else                              w = r1;
    hold_v = 1'b0;
    we  = w ? m1_we    : m0_we;
    a   = w ? m1_addr  : m0_addr;
    d   = w ? m1_wdata : m0_wdata;
    lk  = w ? m1_lock  : m0_lock;
    lat = we ? 2 : 2 + RD_LAT;
    exp_rd = we ? '0 : exp_mem[a];
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      cur_k = k;
      chk("write_en", DW'(write_en), DW'(k == 1 && we));
      chk("read_en",  DW'(read_en),  DW'(k == 1 && !we));
      chk("busy",     DW'(busy),     DW'(k >= 1 && k <= lat));
      chk("gnt",      DW'(gnt),      (k >= 1 && k <= lat) ? (w ? DW'(2) : DW'(1)) : '0);
      chk("m0_ack",   DW'(m0_ack),   DW'(k == lat && !w));
      chk("m1_ack",   DW'(m1_ack),   DW'(k == lat && w));
      chk("m0_rdata", m0_rdata,      (k == lat && !w) ? exp_rd : '0);
      chk("m1_rdata", m1_rdata,      (k == lat && w) ? exp_rd : '0);
      if (k >= 1) begin
        chk("addr_o", DW'(addr_o), DW'(a));
        chk("wdata",  wdata,       d);
      end
      if (k < lat) begin
        next_cycle();
        if (k == 1) begin
          if (w) begin
            m1_addr = AW'($urandom); m1_wdata = $urandom; m1_we = ~m1_we;
            if (drop) m1_req = 1'b0;
          end else begin
            m0_addr = AW'($urandom); m0_wdata = $urandom; m0_we = ~m0_we;
            if (drop) m0_req = 1'b0;
          end
        end
      end
    end
    if (we) exp_mem[a] = d;
    if (LOCK_EN && lk) begin
      hold_v = 1'b1;
      hold_m = w;
    end else begin
      last_m = w;
    end
  endtask

  task automatic set_m0(input bit req, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit lk);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_lock = lk;
  endtask

  task automatic set_m1(input bit req, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit lk);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lk;
  endtask

  initial begin
    logic [1:0] r;
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    exp_mem[28] = 32'h0000_0100;
    set_m0(1'b0, 1'b0, '0, '0, 1'b0);
    set_m1(1'b0, 1'b0, '0, '0, 1'b0);
    hold_m = 1'b0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr_o", DW'(addr_o), '0);
    chk("rst_wdata",  wdata,       '0);
    idle_check("rst");
    do_reset();

    // m0 write 0x00 <= 0xF
    next_cycle();
    set_m0(1'b1, 1'b1, 5'h00, 32'h0000_000F, 1'b0);
    run_txn(1'b0);

    // m1 read 0x1C returns 0x100
    next_cycle();
    set_m0(1'b0, 1'b0, '0, '0, 1'b0);
    set_m1(1'b1, 1'b0, 5'h1C, '0, 1'b0);
    run_txn(1'b0);

    // Simultaneous requests right after reset, held: m0, m1, m0, m1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      set_m0(1'b1, 1'b1, AW'(i), 32'hA000_0000 + i, 1'b0);
      set_m1(1'b1, 1'b0, AW'(i + 8), '0, 1'b0);
      run_txn(1'b0);
    end

    // m0 drops req after ISSUE; no second strobe afterwards
    next_cycle();
    set_m1(1'b0, 1'b0, '0, '0, 1'b0);
    set_m0(1'b1, 1'b1, 5'h03, 32'h1234_5678, 1'b0);
    run_txn(1'b1);
    next_cycle();
    idle_check("drop_idle0");
    next_cycle();
    idle_check("drop_idle1");

    // Reset during WAIT of a read
    next_cycle();
    set_m0(1'b1, 1'b0, 5'h08, '0, 1'b0);
    next_cycle();
    @(negedge clk);
    cur_k = 1;
    chk("abort_ren_issue", DW'(read_en), DW'(1));
    next_cycle();
    m0_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ren",  DW'(read_en), '0);
    chk("abort_busy", DW'(busy),    '0);
    chk("abort_gnt",  DW'(gnt),     '0);
    chk("abort_ack0", DW'(m0_ack),  '0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_noack0", DW'(m0_ack), '0);
      chk("abort_noack1", DW'(m1_ack), '0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_m = 1'b1;
    hold_v = 1'b0;
    next_cycle();
    set_m0(1'b1, 1'b1, 5'h05, 32'h5555_AAAA, 1'b0);
    run_txn(1'b0);

    // Lock: m1 alone, then m0 locked read 0x04 vs m1, then m0 write 0x04 vs m1
    next_cycle();
    set_m0(1'b0, 1'b0, '0, '0, 1'b0);
    set_m1(1'b1, 1'b1, 5'h10, 32'h0000_0010, 1'b0);
    run_txn(1'b0);
    next_cycle();
    set_m0(1'b1, 1'b0, 5'h04, '0, 1'b1);
    set_m1(1'b1, 1'b1, 5'h11, 32'h0000_0011, 1'b0);
    run_txn(1'b0);
    next_cycle();
    set_m0(1'b1, 1'b1, 5'h04, 32'hCAFE_0004, 1'b0);
    set_m1(1'b1, 1'b1, 5'h11, 32'h0000_0011, 1'b0);
    run_txn(1'b0);
    next_cycle();
    run_txn(1'b0);

    // Randomized transactions
    for (int i = 0; i < 60; i++) begin
      next_cycle();
      if ($urandom_range(0, 5) == 0) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
        idle_check("rnd_idle");
        next_cycle();
      end
      r = 2'($urandom_range(1, 3));
      set_m0(r[0], 1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 3) == 0);
      set_m1(r[1], 1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 3) == 0);
      run_txn($urandom_range(0, 3) == 0);
    end
    next_cycle();
    m0_req = 1'b0;
    m1_req = 1'b0;
    idle_check("end_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
